// File: rtl/pc_sequencer_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : pc_sequencer_if
// Description : Bundles the instruction-memory, decode-side, redirect and
//               status signals of the fetch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if;
  // instruction memory request/ack channel
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  // buffered instruction towards decode
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  // control flow from execute
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  // status
  logic [31:0] pc_out;
  logic        halted;
  logic        misalign_err;

  // sequencer side
  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output instr_valid, instr, instr_pc,
    input  instr_ready,
    input  redirect_valid, redirect_pc, halt,
    output pc_out, halted, misalign_err
  );

  // memory / pipeline side
  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  instr_valid, instr, instr_pc,
    output instr_ready,
    output redirect_valid, redirect_pc, halt,
    input  pc_out, halted, misalign_err
  );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : pc_sequencer
// Description : Owns the program counter, issues instruction fetches over a
//               req/ack handshake, buffers the returned word for decode and
//               handles redirects, halt and misaligned-target traps.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic      clk,
  input  wire logic      rst,
  pc_sequencer_if.master bus
);

  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_VALID  = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  logic [1:0]  state_q,    state_d;
  logic [31:0] pc_q,       pc_d;
  logic [31:0] instr_q,    instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        kill_q,     kill_d;      // outstanding fetch must be discarded, then jump to pend_pc
  logic [31:0] pend_pc_q,  pend_pc_d;
  logic        stop_q,     stop_d;      // outstanding fetch must be discarded, then halt
  logic        misalign_q, misalign_d;

  logic w_redir_ok;
  logic w_redir_bad;
  logic w_stop;

  assign w_redir_ok  = bus.redirect_valid && (bus.redirect_pc[1:0] == 2'b00);
  assign w_redir_bad = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
  assign w_stop      = bus.halt || w_redir_bad || stop_q;

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
      kill_q     <= 1'b0;
      pend_pc_q  <= 32'h0;
      stop_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      kill_q     <= kill_d;
      pend_pc_q  <= pend_pc_d;
      stop_q     <= stop_d;
      misalign_q <= misalign_d;
    end
  end

  // Next-state and next-PC decision; halt/trap outranks redirect, redirect outranks pc+4
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    kill_d     = kill_q;
    pend_pc_d  = pend_pc_q;
    stop_d     = stop_q;
    misalign_d = misalign_q;

    if ((state_q != ST_HALTED) && w_redir_bad) begin
      misalign_d = 1'b1;
    end

    case (state_q)
      ST_BOOT: begin
        if (bus.halt || w_redir_bad) begin
          state_d = ST_HALTED;
        end else begin
          if (w_redir_ok) begin
            pc_d = bus.redirect_pc;
          end
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (bus.imem_ack) begin
          kill_d = 1'b0;
          stop_d = 1'b0;
          if (w_stop) begin
            state_d = ST_HALTED;
          end else if (w_redir_ok) begin
            pc_d = bus.redirect_pc;
          end else if (kill_q) begin
            pc_d = pend_pc_q;
          end else begin
            instr_d    = bus.imem_rdata;
            instr_pc_d = pc_q;
            state_d    = ST_VALID;
          end
        end else if (w_stop) begin
          stop_d = 1'b1;
        end else if (w_redir_ok) begin
          kill_d    = 1'b1;
          pend_pc_d = bus.redirect_pc;
        end
      end
      ST_VALID: begin
        if (bus.halt || w_redir_bad) begin
          state_d = ST_HALTED;
        end else if (w_redir_ok) begin
          pc_d    = bus.redirect_pc;
          state_d = ST_FETCH;
        end else if (bus.instr_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_HALTED;
      end
    endcase
  end

  // Outputs decoded from state and registers only
  always_comb begin
    bus.imem_req     = (state_q == ST_FETCH);
    bus.imem_addr    = pc_q;
    bus.instr_valid  = (state_q == ST_VALID);
    bus.instr        = instr_q;
    bus.instr_pc     = instr_pc_q;
    bus.pc_out       = pc_q;
    bus.halted       = (state_q == ST_HALTED);
    bus.misalign_err = misalign_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer: directed scenarios plus
//               a randomized run scored against a fetch-stream model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  pc_sequencer_if bus();

  pc_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // instruction memory contents as a pure function of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // drive one cycle of inputs at a falling edge, then wait for the next falling edge
  task automatic tick(input logic ack, input logic ready, input logic rv,
                      input logic [31:0] rpc, input logic h);
    bus.imem_ack       = ack;
    bus.imem_rdata     = ack ? mem_word(bus.imem_addr) : $urandom;
    bus.instr_ready    = ready;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.halt           = h;
    @(negedge clk);
  endtask

  // reset pulse; returns one cycle after release with the sequencer in FETCH at RST_PC
  task automatic do_reset();
    rst = 1'b1;
    bus.imem_ack = 1'b0; bus.instr_ready = 1'b0; bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0; bus.halt = 1'b0; bus.imem_rdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.imem_ack = 1'b0; bus.instr_ready = 1'b0; bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0; bus.halt = 1'b0; bus.imem_rdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (bus.pc_out !== RST_PC) begin bad++; $display("FAIL reset_pc: got %h want %h", bus.pc_out, RST_PC); end
    total++;
    if ({bus.imem_req, bus.instr_valid, bus.halted, bus.misalign_err} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags: got %b want 0000", {bus.imem_req, bus.instr_valid, bus.halted, bus.misalign_err});
    end
    total++;
    if ({bus.instr, bus.instr_pc} !== 64'h0) begin bad++; $display("FAIL reset_instr: got %h/%h want 0/0", bus.instr, bus.instr_pc); end
    rst = 1'b0;
    #1;
    total++;
    if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL boot_no_req: got %b want 0", bus.imem_req); end
    @(negedge clk);
    total++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC) begin
      bad++; $display("FAIL first_req: got req=%b addr=%h want req=1 addr=%h", bus.imem_req, bus.imem_addr, RST_PC);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      a = RST_PC + 32'(4 * i);
      total++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== a) begin
        bad++; $display("FAIL seq_addr: got req=%b addr=%h want req=1 addr=%h", bus.imem_req, bus.imem_addr, a);
      end
      tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      total++;
      if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_pc !== a || bus.instr !== mem_word(a)) begin
        bad++; $display("FAIL seq_instr: got v=%b req=%b pc=%h ins=%h want v=1 req=0 pc=%h ins=%h",
                        bus.instr_valid, bus.imem_req, bus.instr_pc, bus.instr, a, mem_word(a));
      end
      tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    end
    total++;
    if (bus.imem_addr !== RST_PC + 32'hC) begin bad++; $display("FAIL seq_next: got %h want %h", bus.imem_addr, RST_PC + 32'hC); end
  endtask

  task automatic test_ack_delay_stall();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({bus.imem_req, bus.instr_valid, bus.imem_addr} !== {1'b1, 1'b0, RST_PC}) begin
        bad++; $display("FAIL delay_hold: got req=%b v=%b addr=%h want req=1 v=0 addr=%h", bus.imem_req, bus.instr_valid, bus.imem_addr, RST_PC);
      end
      tick((k == 3), 1'b0, 1'b0, 32'h0, 1'b0);
    end
    total++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== RST_PC) begin
      bad++; $display("FAIL delay_valid: got v=%b pc=%h want v=1 pc=%h", bus.instr_valid, bus.instr_pc, RST_PC);
    end
    for (int k = 0; k < 5; k++) begin
      tick(1'($urandom_range(0, 1)), 1'b0, 1'b0, 32'h0, 1'b0);
      total++;
      if ({bus.instr_valid, bus.imem_req, bus.instr, bus.instr_pc} !== {1'b1, 1'b0, mem_word(RST_PC), RST_PC}) begin
        bad++; $display("FAIL stall_hold: got v=%b req=%b ins=%h pc=%h want v=1 req=0 ins=%h pc=%h",
                        bus.instr_valid, bus.imem_req, bus.instr, bus.instr_pc, mem_word(RST_PC), RST_PC);
      end
    end
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    total++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC + 32'd4) begin
      bad++; $display("FAIL stall_next: got req=%b addr=%h want req=1 addr=%h", bus.imem_req, bus.imem_addr, RST_PC + 32'd4);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    repeat (2) begin
      tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    end
    // redirect while the fetch of 0x108 is outstanding
    tick(1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    total++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h108) begin
      bad++; $display("FAIL kill_hold: got req=%b addr=%h want req=1 addr=00000108", bus.imem_req, bus.imem_addr);
    end
    tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    total++;
    if ({bus.instr_valid, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 32'h200}) begin
      bad++; $display("FAIL kill_target: got v=%b req=%b addr=%h want v=0 req=1 addr=00000200", bus.instr_valid, bus.imem_req, bus.imem_addr);
    end
    tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    total++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h200 || bus.instr !== mem_word(32'h200)) begin
      bad++; $display("FAIL kill_instr: got v=%b pc=%h ins=%h want v=1 pc=00000200 ins=%h", bus.instr_valid, bus.instr_pc, bus.instr, mem_word(32'h200));
    end
    // redirect in VALID
    tick(1'b0, 1'b0, 1'b1, 32'h300, 1'b0);
    total++;
    if ({bus.instr_valid, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 32'h300}) begin
      bad++; $display("FAIL valid_redirect: got v=%b req=%b addr=%h want v=0 req=1 addr=00000300", bus.instr_valid, bus.imem_req, bus.imem_addr);
    end
    tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    // redirect together with accept: target beats pc+4
    tick(1'b0, 1'b1, 1'b1, 32'h200, 1'b0);
    total++;
    if ({bus.instr_valid, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 32'h200}) begin
      bad++; $display("FAIL ready_redirect: got v=%b req=%b addr=%h want v=0 req=1 addr=00000200", bus.instr_valid, bus.imem_req, bus.imem_addr);
    end
    // redirect in FETCH with ack in the same cycle
    tick(1'b1, 1'b0, 1'b1, 32'h400, 1'b0);
    total++;
    if ({bus.instr_valid, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 32'h400}) begin
      bad++; $display("FAIL ack_redirect: got v=%b req=%b addr=%h want v=0 req=1 addr=00000400", bus.instr_valid, bus.imem_req, bus.imem_addr);
    end
    tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    // two redirects while one fetch is outstanding: the later one wins
    tick(1'b0, 1'b0, 1'b1, 32'h500, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 32'h600, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    total++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h600) begin
      bad++; $display("FAIL double_redirect: got v=%b pc=%h want v=1 pc=00000600", bus.instr_valid, bus.instr_pc);
    end
  endtask

  task automatic test_misalign();
    do_reset();
    tick(1'b0, 1'b0, 1'b1, 32'h201, 1'b0);
    total++;
    if ({bus.misalign_err, bus.halted, bus.imem_req, bus.imem_addr} !== {1'b1, 1'b0, 1'b1, RST_PC}) begin
      bad++; $display("FAIL mis_fetch_wait: got err=%b h=%b req=%b addr=%h want err=1 h=0 req=1 addr=%h",
                      bus.misalign_err, bus.halted, bus.imem_req, bus.imem_addr, RST_PC);
    end
    tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    total++;
    if ({bus.halted, bus.imem_req, bus.instr_valid, bus.pc_out} !== {1'b1, 1'b0, 1'b0, RST_PC}) begin
      bad++; $display("FAIL mis_fetch_halt: got h=%b req=%b v=%b pc=%h want h=1 req=0 v=0 pc=%h",
                      bus.halted, bus.imem_req, bus.instr_valid, bus.pc_out, RST_PC);
    end
    do_reset();
    total++;
    if (bus.misalign_err !== 1'b0 || bus.halted !== 1'b0) begin
      bad++; $display("FAIL mis_reset_clear: got err=%b h=%b want 0 0", bus.misalign_err, bus.halted);
    end
    tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 32'h202, 1'b0);
    for (int k = 0; k < 6; k++) begin
      total++;
      if ({bus.misalign_err, bus.halted, bus.imem_req, bus.instr_valid, bus.pc_out} !== {1'b1, 1'b1, 1'b0, 1'b0, RST_PC}) begin
        bad++; $display("FAIL mis_sticky: got err=%b h=%b req=%b v=%b pc=%h want err=1 h=1 req=0 v=0 pc=%h",
                        bus.misalign_err, bus.halted, bus.imem_req, bus.instr_valid, bus.pc_out, RST_PC);
      end
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 32'($urandom_range(0, 255)) << 2, 1'b0);
    end
    // halt together with a misaligned redirect: halts, and the error still records
    do_reset();
    tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 32'h303, 1'b1);
    total++;
    if ({bus.misalign_err, bus.halted, bus.pc_out} !== {1'b1, 1'b1, RST_PC}) begin
      bad++; $display("FAIL halt_and_mis: got err=%b h=%b pc=%h want err=1 h=1 pc=%h", bus.misalign_err, bus.halted, bus.pc_out, RST_PC);
    end
  endtask

  task automatic test_wrap_halt_reset();
    do_reset();
    tick(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    total++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'hFFFF_FFFC) begin
      bad++; $display("FAIL wrap_instr: got v=%b pc=%h want v=1 pc=fffffffc", bus.instr_valid, bus.instr_pc);
    end
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    total++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      bad++; $display("FAIL wrap_addr: got req=%b addr=%h want req=1 addr=00000000", bus.imem_req, bus.imem_addr);
    end
    // halt pulse while the fetch of 0x0 is outstanding
    tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    total++;
    if ({bus.halted, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 32'h0}) begin
      bad++; $display("FAIL halt_wait: got h=%b req=%b addr=%h want h=0 req=1 addr=00000000", bus.halted, bus.imem_req, bus.imem_addr);
    end
    tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    total++;
    if ({bus.halted, bus.imem_req, bus.instr_valid, bus.pc_out} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      bad++; $display("FAIL halt_after_ack: got h=%b req=%b v=%b pc=%h want h=1 req=0 v=0 pc=00000000",
                      bus.halted, bus.imem_req, bus.instr_valid, bus.pc_out);
    end
    // asynchronous reset in the middle of a fetch of 0x104
    do_reset();
    tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    #1;
    total++;
    if (bus.imem_req !== 1'b0 || bus.pc_out !== RST_PC) begin
      bad++; $display("FAIL async_reset: got req=%b pc=%h want req=0 pc=%h", bus.imem_req, bus.pc_out, RST_PC);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // random traffic: every presented instruction must be the one the control flow predicts
  task automatic test_random(input int n);
    logic [31:0] exp_pc;
    logic [31:0] cur_pc;
    logic [31:0] prev_addr;
    logic        prev_req;
    logic        prev_ack;
    logic        prev_valid;
    logic        ack;
    logic        ready;
    logic        rv;
    logic [31:0] rpc;
    int          presented;
    do_reset();
    exp_pc = RST_PC; cur_pc = 32'h0; prev_addr = 32'h0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_valid = 1'b0; presented = 0;
    for (int c = 0; c < n; c++) begin
      if (bus.instr_valid && !prev_valid) begin
        presented++;
        total++;
        if (bus.instr_pc !== exp_pc || bus.instr !== mem_word(exp_pc)) begin
          bad++; $display("FAIL rand_stream: got pc=%h ins=%h want pc=%h ins=%h", bus.instr_pc, bus.instr, exp_pc, mem_word(exp_pc));
        end
        cur_pc = exp_pc;
      end
      if (prev_req && !prev_ack) begin
        total++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== prev_addr) begin
          bad++; $display("FAIL rand_req_stable: got req=%b addr=%h want req=1 addr=%h", bus.imem_req, bus.imem_addr, prev_addr);
        end
      end
      if ((bus.imem_req && bus.instr_valid) || bus.halted) begin
        total++; bad++;
        $display("FAIL rand_exclusive: got req=%b v=%b h=%b want no overlap, not halted", bus.imem_req, bus.instr_valid, bus.halted);
      end
      ack   = ($urandom_range(0, 2) == 0);
      ready = 1'($urandom_range(0, 1));
      rv    = ($urandom_range(0, 9) == 0);
      rpc   = 32'($urandom_range(0, 255)) << 2;
      if (rv) exp_pc = rpc;
      else if (bus.instr_valid && ready) exp_pc = cur_pc + 32'd4;
      prev_valid = bus.instr_valid;
      prev_req   = bus.imem_req;
      prev_addr  = bus.imem_addr;
      prev_ack   = ack;
      tick(ack, ready, rv, rpc, 1'b0);
    end
    total++;
    if (presented < n / 20) begin
      bad++; $display("FAIL rand_progress: got %0d presentations want at least %0d", presented, n / 20);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0; bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0; bus.halt = 1'b0;
    test_reset();
    test_sequential();
    test_ack_delay_stall();
    test_redirect();
    test_misalign();
    test_wrap_halt_reset();
    test_random(3000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
